// File: rtl/hu_audioenc_dma32_responder_if.sv
// DMA32 control/data handshake bundle between an accelerator (master) and the memory-side responder (slave).
interface hu_audioenc_dma32_responder_if;
  logic        dma_read_ctrl_valid;
  logic        dma_read_ctrl_ready;
  logic [31:0] dma_read_ctrl_data_index;
  logic [31:0] dma_read_ctrl_data_length;
  logic [2:0]  dma_read_ctrl_data_size;
  logic        dma_read_chnl_valid;
  logic        dma_read_chnl_ready;
  logic [31:0] dma_read_chnl_data;
  logic        dma_write_ctrl_valid;
  logic        dma_write_ctrl_ready;
  logic [31:0] dma_write_ctrl_data_index;
  logic [31:0] dma_write_ctrl_data_length;
  logic [2:0]  dma_write_ctrl_data_size;
  logic        dma_write_chnl_valid;
  logic        dma_write_chnl_ready;
  logic [31:0] dma_write_chnl_data;

  modport master (
    output dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length,
           dma_read_ctrl_data_size, dma_read_chnl_ready,
           dma_write_ctrl_valid, dma_write_ctrl_data_index, dma_write_ctrl_data_length,
           dma_write_ctrl_data_size, dma_write_chnl_valid, dma_write_chnl_data,
    input  dma_read_ctrl_ready, dma_read_chnl_valid, dma_read_chnl_data,
           dma_write_ctrl_ready, dma_write_chnl_ready
  );

  modport slave (
    input  dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length,
           dma_read_ctrl_data_size, dma_read_chnl_ready,
           dma_write_ctrl_valid, dma_write_ctrl_data_index, dma_write_ctrl_data_length,
           dma_write_ctrl_data_size, dma_write_chnl_valid, dma_write_chnl_data,
    output dma_read_ctrl_ready, dma_read_chnl_valid, dma_read_chnl_data,
           dma_write_ctrl_ready, dma_write_chnl_ready
  );
endinterface

// File: rtl/hu_audioenc_dma32_responder.sv
// DMA32 memory responder: read data valid 1 cycle after ctrl handshake, then 1 beat/cycle;
// read data held while chnl_ready is low, write beats accepted whenever chnl_valid is high.
module hu_audioenc_dma32_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  hu_audioenc_dma32_responder_if.slave dma,
  input  logic                         host_we,
  input  logic [ADDR_W-1:0]            host_addr,
  input  logic [31:0]                  host_wdata,
  output logic [31:0]                  host_rdata,
  output logic                         busy,
  output logic                         size_err,
  output logic [15:0]                  xfer_count
);
  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t            state;
  logic [31:0]       mem [MEM_WORDS];
  logic [31:0]       base, len, beat, beat_nxt;
  logic              ctrl_rdy, rd_vld, wr_rdy;
  logic [31:0]       rd_dat;
  logic [ADDR_W-1:0] cur_addr, nxt_addr;
  logic              rd_req, wr_req, rd_fire, wr_fire, last_beat;
  logic [31:0]       req_idx, req_len;
  logic [2:0]        req_size;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  assign beat_nxt  = beat + 32'd1;
  assign cur_addr  = ADDR_W'(base + beat);
  assign nxt_addr  = ADDR_W'(base + beat_nxt);
  assign last_beat = (beat_nxt == len);

  // Read wins a simultaneous request, so the request mux keys off read valid alone.
  assign rd_req   = ctrl_rdy & dma.dma_read_ctrl_valid;
  assign wr_req   = ctrl_rdy & ~dma.dma_read_ctrl_valid & dma.dma_write_ctrl_valid;
  assign req_idx  = dma.dma_read_ctrl_valid ? dma.dma_read_ctrl_data_index  : dma.dma_write_ctrl_data_index;
  assign req_len  = dma.dma_read_ctrl_valid ? dma.dma_read_ctrl_data_length : dma.dma_write_ctrl_data_length;
  assign req_size = dma.dma_read_ctrl_valid ? dma.dma_read_ctrl_data_size   : dma.dma_write_ctrl_data_size;
  assign rd_fire  = rd_vld & dma.dma_read_chnl_ready;
  assign wr_fire  = wr_rdy & dma.dma_write_chnl_valid;

  assign dma.dma_read_ctrl_ready  = ctrl_rdy;
  assign dma.dma_write_ctrl_ready = ctrl_rdy & ~dma.dma_read_ctrl_valid;
  assign dma.dma_read_chnl_valid  = rd_vld;
  assign dma.dma_read_chnl_data   = rd_dat;
  assign dma.dma_write_chnl_ready = wr_rdy;
  assign busy                     = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ctrl_rdy   <= 1'b0;
      rd_vld     <= 1'b0;
      wr_rdy     <= 1'b0;
      rd_dat     <= '0;
      base       <= '0;
      len        <= '0;
      beat       <= '0;
      size_err   <= 1'b0;
      xfer_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          ctrl_rdy <= 1'b1;
          if (rd_req || wr_req) begin
            base <= req_idx;
            len  <= req_len;
            beat <= '0;
            if (req_size != 3'b010) size_err <= 1'b1;
            if (req_len == 32'd0) begin
              xfer_count <= xfer_count + 16'd1;
            end else if (rd_req) begin
              state    <= RD;
              ctrl_rdy <= 1'b0;
              rd_vld   <= 1'b1;
              rd_dat   <= mem[req_idx[ADDR_W-1:0]];
            end else begin
              state    <= WR;
              ctrl_rdy <= 1'b0;
              wr_rdy   <= 1'b1;
            end
          end
        end
        RD: begin
          if (rd_fire) begin
            if (last_beat) begin
              rd_vld     <= 1'b0;
              state      <= IDLE;
              ctrl_rdy   <= 1'b1;
              xfer_count <= xfer_count + 16'd1;
            end else begin
              beat   <= beat_nxt;
              rd_dat <= mem[nxt_addr];
            end
          end
        end
        WR: begin
          if (wr_fire) begin
            beat <= beat_nxt;
            if (last_beat) begin
              wr_rdy     <= 1'b0;
              state      <= IDLE;
              ctrl_rdy   <= 1'b1;
              xfer_count <= xfer_count + 16'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Burst writes and host writes never collide: the host port is locked out while busy.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = host_addr;
    mem_wdata = host_wdata;
    if (wr_fire) begin
      mem_we    = 1'b1;
      mem_addr  = cur_addr;
      mem_wdata = dma.dma_write_chnl_data;
    end else if (host_we && !busy) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) host_rdata <= '0;
    else      host_rdata <= mem[host_addr];
  end
endmodule

// File: tb/tb_hu_audioenc_dma32_responder.sv
// Directed + randomized bench for the DMA32 responder against a word-array memory model.
module tb_hu_audioenc_dma32_responder;
  localparam int MEM_WORDS = 1024;
  localparam int ADDR_W    = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [31:0]       host_wdata;
  logic [31:0]       host_rdata;
  logic              busy;
  logic              size_err;
  logic [15:0]       xfer_count;

  hu_audioenc_dma32_responder_if dma();

  hu_audioenc_dma32_responder #(.MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .dma        (dma),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .busy       (busy),
    .size_err   (size_err),
    .xfer_count (xfer_count)
  );

  always #5 clk = ~clk;

  logic [31:0] model_mem [MEM_WORDS];
  logic [15:0] exp_xfer;
  logic        exp_size_err;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int maddr(input logic [31:0] idx, input int k);
    logic [31:0] s;
    s = idx + 32'(k);
    return int'(s % 32'(MEM_WORDS));
  endfunction

  task automatic host_write(input int a, input logic [31:0] d);
    host_we    = 1'b1;
    host_addr  = ADDR_W'(a);
    host_wdata = d;
    model_mem[a] = d;
    @(posedge clk); #1;
    host_we = 1'b0;
  endtask

  task automatic host_read(input int a, output logic [31:0] d);
    host_addr = ADDR_W'(a);
    @(posedge clk); #1;
    d = host_rdata;
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", busy, 0);
    check("rst_rd_ctrl_rdy", dma.dma_read_ctrl_ready, 0);
    check("rst_wr_ctrl_rdy", dma.dma_write_ctrl_ready, 0);
    check("rst_rd_chnl_vld", dma.dma_read_chnl_valid, 0);
    check("rst_wr_chnl_rdy", dma.dma_write_chnl_ready, 0);
    check("rst_xfer", xfer_count, 0);
    check("rst_size_err", size_err, 0);
  endtask

  task automatic do_reset();
    dma.dma_read_ctrl_valid  = 1'b0;
    dma.dma_write_ctrl_valid = 1'b0;
    dma.dma_write_chnl_valid = 1'b0;
    dma.dma_read_chnl_ready  = 1'b0;
    rst = 1'b0;
    #1;
    check_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b1;
    exp_xfer     = '0;
    exp_size_err = 1'b0;
  endtask

  // mode: 0 ready always high, 1 ready pattern 1,0,0 repeating, 2 random ready
  task automatic do_read(input logic [31:0] idx, input logic [31:0] len, input logic [2:0] sz, input int mode);
    int t, k, cyc;
    logic rdy, prev_stall;
    logic [31:0] prev_dat;
    dma.dma_read_ctrl_valid       = 1'b1;
    dma.dma_read_ctrl_data_index  = idx;
    dma.dma_read_ctrl_data_length = len;
    dma.dma_read_ctrl_data_size   = sz;
    #1;
    t = 0;
    while (dma.dma_read_ctrl_ready !== 1'b1 && t < 100) begin
      @(posedge clk); #1; t++;
    end
    check("rd_ctrl_wait", (t < 100), 1);
    if (dma.dma_write_ctrl_valid) check("wr_ctrl_gated", dma.dma_write_ctrl_ready, 0);
    @(posedge clk); #1;
    dma.dma_read_ctrl_valid = 1'b0;
    if (sz != 3'b010) exp_size_err = 1'b1;
    if (len == 0) begin
      exp_xfer++;
      check("rd_len0_novld", dma.dma_read_chnl_valid, 0);
      check("rd_len0_xfer", xfer_count, exp_xfer);
      check("rd_len0_size_err", size_err, exp_size_err);
      return;
    end
    check("rd_busy", busy, 1);
    check("rd_ctrl_rdy_low", dma.dma_read_ctrl_ready, 0);
    k = 0; cyc = 0; prev_stall = 1'b0; prev_dat = '0;
    while (k < len && cyc < 5000) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      dma.dma_read_chnl_ready = rdy;
      check("rd_vld", dma.dma_read_chnl_valid, 1);
      if (prev_stall) check("rd_stall_hold", dma.dma_read_chnl_data, prev_dat);
      if (rdy) begin
        check("rd_data", dma.dma_read_chnl_data, model_mem[maddr(idx, k)]);
        k++;
      end
      prev_stall = !rdy;
      prev_dat   = dma.dma_read_chnl_data;
      @(posedge clk); #1; cyc++;
    end
    dma.dma_read_chnl_ready = 1'b0;
    check("rd_beats", k, len);
    if (mode == 0) check("rd_no_bubble", cyc, len);
    check("rd_done_vld", dma.dma_read_chnl_valid, 0);
    check("rd_done_busy", busy, 0);
    exp_xfer++;
    check("rd_xfer", xfer_count, exp_xfer);
    check("rd_size_err", size_err, exp_size_err);
  endtask

  task automatic do_write(input logic [31:0] idx, input logic [31:0] len, input logic [2:0] sz,
                          input logic [31:0] dbase, input bit rnd, input int abort_at);
    int t, k, cyc;
    logic v;
    logic [31:0] d;
    dma.dma_write_ctrl_valid       = 1'b1;
    dma.dma_write_ctrl_data_index  = idx;
    dma.dma_write_ctrl_data_length = len;
    dma.dma_write_ctrl_data_size   = sz;
    #1;
    t = 0;
    while (dma.dma_write_ctrl_ready !== 1'b1 && t < 100) begin
      @(posedge clk); #1; t++;
    end
    check("wr_ctrl_wait", (t < 100), 1);
    @(posedge clk); #1;
    dma.dma_write_ctrl_valid = 1'b0;
    if (sz != 3'b010) exp_size_err = 1'b1;
    if (len == 0) begin
      exp_xfer++;
      check("wr_len0_rdy", dma.dma_write_chnl_ready, 0);
      check("wr_len0_xfer", xfer_count, exp_xfer);
      return;
    end
    check("wr_busy", busy, 1);
    k = 0; cyc = 0;
    while (k < len && cyc < 5000) begin
      v = ($urandom_range(0, 3) != 0);
      d = rnd ? $urandom : dbase + 32'(k);
      dma.dma_write_chnl_valid = v;
      dma.dma_write_chnl_data  = d;
      check("wr_chnl_rdy", dma.dma_write_chnl_ready, 1);
      if (v) begin
        model_mem[maddr(idx, k)] = d;
        k++;
      end
      @(posedge clk); #1; cyc++;
      if (k == abort_at) break;
    end
    dma.dma_write_chnl_valid = 1'b0;
    if (k == abort_at) return;
    check("wr_beats", k, len);
    check("wr_done_rdy", dma.dma_write_chnl_ready, 0);
    check("wr_done_busy", busy, 0);
    exp_xfer++;
    check("wr_xfer", xfer_count, exp_xfer);
    check("wr_size_err", size_err, exp_size_err);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] ridx, rlen;
    rst        = 1'b0;
    host_we    = 1'b0;
    host_addr  = '0;
    host_wdata = '0;
    dma.dma_read_ctrl_valid        = 1'b0;
    dma.dma_read_ctrl_data_index   = '0;
    dma.dma_read_ctrl_data_length  = '0;
    dma.dma_read_ctrl_data_size    = 3'b010;
    dma.dma_read_chnl_ready        = 1'b0;
    dma.dma_write_ctrl_valid       = 1'b0;
    dma.dma_write_ctrl_data_index  = '0;
    dma.dma_write_ctrl_data_length = '0;
    dma.dma_write_ctrl_data_size   = 3'b010;
    dma.dma_write_chnl_valid       = 1'b0;
    dma.dma_write_chnl_data        = '0;
    exp_xfer     = '0;
    exp_size_err = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    check("rst_rd_data", dma.dma_read_chnl_data, 0);
    check("rst_host_rdata", host_rdata, 0);
    rst = 1'b1;

    for (int i = 0; i < MEM_WORDS; i++)
      host_write(i, (i < 8) ? 32'h100 + 32'(i) : $urandom);
    host_read(3, rd);
    check("host_preload", rd, 32'h103);

    // Plain read, then the same read under a stalling consumer
    do_read(32'd2, 32'd4, 3'b010, 0);
    check("xfer_after_rd1", xfer_count, 1);
    do_read(32'd2, 32'd4, 3'b010, 1);

    // Write that wraps past the top of memory
    do_reset();
    do_write(32'(MEM_WORDS - 2), 32'd4, 3'b010, 32'hA0, 1'b0, -1);
    host_read(MEM_WORDS - 2, rd); check("wrap_1022", rd, 32'hA0);
    host_read(MEM_WORDS - 1, rd); check("wrap_1023", rd, 32'hA1);
    host_read(0, rd);             check("wrap_0", rd, 32'hA2);
    host_read(1, rd);             check("wrap_1", rd, 32'hA3);

    // Simultaneous read and write requests: read first, write on the next idle cycle
    do_reset();
    dma.dma_write_ctrl_valid       = 1'b1;
    dma.dma_write_ctrl_data_index  = 32'd100;
    dma.dma_write_ctrl_data_length = 32'd3;
    dma.dma_write_ctrl_data_size   = 3'b010;
    do_read(32'd10, 32'd5, 3'b010, 2);
    check("wr_rdy_after_rd", dma.dma_write_ctrl_ready, 1);
    do_write(32'd100, 32'd3, 3'b010, 32'h0, 1'b1, -1);
    check("xfer_both", xfer_count, 2);
    do_read(32'd99, 32'd5, 3'b010, 0);

    // Zero-length read, then a read with an unsupported size code
    do_reset();
    do_read(32'd0, 32'd0, 3'b010, 0);
    do_read(32'd5, 32'd3, 3'b011, 0);
    check("size_err_set", size_err, 1);
    check("xfer_len0_pair", xfer_count, 2);

    // Reset in the middle of a write burst
    do_reset();
    do_write(32'd200, 32'd4, 3'b010, 32'h0, 1'b1, 2);
    do_reset();
    for (int i = 200; i < 204; i++) begin
      host_read(i, rd);
      check("partial_wr_mem", rd, model_mem[i]);
    end
    do_read(32'd200, 32'd4, 3'b010, 2);

    // Randomized traffic
    for (int i = 0; i < 24; i++) begin
      ridx = $urandom;
      rlen = 32'($urandom_range(0, 12));
      if ($urandom_range(0, 1) == 1) do_read(ridx, rlen, 3'b010, int'($urandom_range(0, 2)));
      else                           do_write(ridx, rlen, 3'b010, 32'h0, 1'b1, -1);
    end

    // Burst longer than the memory
    do_write(32'd1020, 32'(MEM_WORDS + 6), 3'b010, 32'h0, 1'b1, -1);
    do_read(32'd1020, 32'(MEM_WORDS + 6), 3'b010, 2);

    for (int i = 0; i < 16; i++) begin
      int a;
      a = int'($urandom_range(0, MEM_WORDS - 1));
      host_read(a, rd);
      check("host_sweep", rd, model_mem[a]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/hu_audioenc_dma32_responder.md
Name: hu_audioenc_dma32_responder

Overview:
- Memory-side responder for the 32-bit ESP accelerator DMA interface: services read/write control requests from an accelerator (e.g. the audio encoder) and moves data between its DMA channels and a local word-addressed memory.
- Used as the platform/bench counterpart for dma32 accelerators.
- Includes a host backdoor port to preload and inspect memory while no burst is active.

Parameters:
- MEM_WORDS, 1024: depth of the internal memory in 32-bit words; must be a power of two.
- ADDR_W, 10: log2(MEM_WORDS).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- dma_read_ctrl_valid  in  1  read request valid
- dma_read_ctrl_ready  out  1  read request accepted
- dma_read_ctrl_data_index  in  32  start word index
- dma_read_ctrl_data_length  in  32  beats to return
- dma_read_ctrl_data_size  in  3  beat size code
- dma_read_chnl_valid  out  1  read data valid
- dma_read_chnl_ready  in  1  accelerator accepts read data
- dma_read_chnl_data  out  32  read data
- dma_write_ctrl_valid  in  1  write request valid
- dma_write_ctrl_ready  out  1  write request accepted
- dma_write_ctrl_data_index  in  32  start word index
- dma_write_ctrl_data_length  in  32  beats to accept
- dma_write_ctrl_data_size  in  3  beat size code
- dma_write_chnl_valid  in  1  write data valid
- dma_write_chnl_ready  out  1  responder accepts write data
- dma_write_chnl_data  in  32  write data
- host_we  in  1  backdoor write strobe
- host_addr  in  ADDR_W  backdoor address
- host_wdata  in  32  backdoor write data
- host_rdata  out  32  backdoor read data, 1-cycle latency
- busy  out  1  burst in progress
- size_err  out  1  sticky: a request arrived with size != 3'b010
- xfer_count  out  16  completed transactions, wraps at 16 bits

Behaviour:
- Reset values:
  - State IDLE; all ready/valid outputs 0; dma_read_chnl_data 0; host_rdata 0; busy 0; size_err 0; xfer_count 0.
  - Memory contents are not reset.
- FSM states: IDLE, RD, WR.
- IDLE:
  - dma_read_ctrl_ready = dma_write_ctrl_ready = 1.
  - If read valid: latch index/length, go to RD. A simultaneous write request sees ready but is NOT consumed; write ready is gated to 0 whenever read valid is 1 (read wins).
  - Else if write valid: latch, go to WR.
  - A length of 0 is accepted: stay IDLE and increment xfer_count next cycle.
- Address generation:
  - addr = (index + beat) mod MEM_WORDS, using the low ADDR_W bits.
  - Wrap-around past the top of memory is legal and silent.
- RD:
  - dma_read_chnl_valid = 1 from the cycle after the ctrl handshake.
  - dma_read_chnl_data = mem[addr] (asynchronous array read, registered to the output with valid).
  - Data and valid are held stable while ready = 0.
  - On valid & ready: beat++ and the next word is presented the next cycle with no bubble.
  - After the last beat is accepted: valid = 0, return to IDLE, xfer_count++.
- WR:
  - dma_write_chnl_ready = 1.
  - On valid & ready: mem[addr] <= data, beat++.
  - After the last beat: ready = 0 the next cycle, return to IDLE, xfer_count++.
- Control ready is 0 in RD and WR. busy = (state != IDLE).
- size: only 3'b010 (word) is supported. Any other code is still serviced as 32-bit words and sets size_err, which is cleared only by reset.
- Host port:
  - host_rdata <= mem[host_addr] every cycle.
  - host_we writes only while busy = 0; it is ignored while busy.
- Beat counter is 32 bits. A burst longer than MEM_WORDS wraps the address and keeps going.
- Reset asserted mid-burst: immediate return to IDLE with all handshake outputs low; a partial write burst leaves already-written words in memory.

Test Plan:
- Host preloads mem[0..7] = 0x100..0x107; read req index=2, length=4 with chnl_ready held 1 -> valid the cycle after ctrl handshake; data 0x102, 0x103, 0x104, 0x105 on consecutive cycles; xfer_count = 1.
- Same read with chnl_ready toggling 1,0,0,1... -> data held stable during stalls; exactly 4 beats, in order, no duplicates.
- Write req index=MEM_WORDS-2, length=4, data 0xA0..0xA3 -> host reads show mem[1022]=0xA0, mem[1023]=0xA1, mem[0]=0xA2, mem[1]=0xA3.
- Read and write ctrl valid in the same cycle -> read accepted first and write_ctrl_ready = 0 that cycle; write accepted on the first IDLE cycle after the read completes; xfer_count = 2.
- length=0 read, then a read with size=3'b011 -> no data beats for the first; size_err = 1; second serviced normally; xfer_count = 2.
- Reset asserted after 2 of 4 write beats -> busy = 0, all readies 0 during reset; mem holds the 2 written words; the next request is serviced normally.
